bcd_stopwatch_ctrl: RTL
=======================

Name: bcd_stopwatch_ctrl

Overview:
Controller that sequences a cascaded multi-digit decade (BCD) counter as a stopwatch. It holds a run/pause/lap state machine and a prescaler that generates count ticks. It performs carry-chained BCD increment across digits and drives a display bus that can be frozen for lap readout. It sits between the front-panel pulse inputs and the digit display; it is the scheduling layer for the decade-counter datapath.

Parameters:
DIGITS, 4, number of BCD digits in the cascade (≥1)
PRESCALE, 10, clock cycles per count tick (≥1)

Ports:
clock  input  1  system clock, rising-edge active
reset  input  1  asynchronous, active-low reset
start_stop  input  1  single-cycle pulse: toggle run/pause
lap  input  1  single-cycle pulse: freeze or release display
clear  input  1  single-cycle pulse: return to zero and idle
display  output  4*DIGITS  shown value; digit 0 (least significant) in [3:0]
count  output  4*DIGITS  live BCD count, always the running value
running  output  1  high in RUN or LAP
lap_active  output  1  high in LAP
overflow  output  1  sticky; set on full wrap from all-9s to 0
tick  output  1  combinational; high in the cycle a count increment occurs

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; count, display, lap register, prescaler all 0; running=0, lap_active=0, overflow=0, tick=0.
- States: IDLE, RUN, PAUSE, LAP. All inputs are sampled on the rising edge of clock.
- Input priority when pulses coincide: clear > start_stop > lap. The lower-priority pulse is ignored in that cycle.
- clear, from any state: go to IDLE next edge; count, prescaler, lap register and overflow cleared. A tick in the same cycle is discarded.
- IDLE: start_stop -> RUN. lap is ignored.
- RUN: start_stop -> PAUSE. lap -> LAP and captures the current count (post-increment value if tick is high that cycle).
- LAP: lap -> RUN (display releases). start_stop -> PAUSE (display releases).
- PAUSE: start_stop -> RUN. lap is ignored.
- Prescaler:
  - Counts 0..PRESCALE-1 only in RUN/LAP.
  - Holds its value in PAUSE; it is not reset, so resuming continues the partial period.
  - tick = (state is RUN or LAP) and prescaler == PRESCALE-1. On that edge the prescaler returns to 0.
  - With PRESCALE=1, tick is high every RUN/LAP cycle.
- Latency: after the start edge from IDLE, count first reads 1 exactly PRESCALE edges later.
- A start_stop leaving RUN/LAP in a tick cycle still applies that cycle's increment.
- BCD increment on tick:
  - Digit 0 increments.
  - Digit k increments iff all digits below it equal 9.
  - A digit at 9 that increments wraps to 0.
  - No digit may ever hold 10–15.
- Full wrap: when all digits are 9 and tick occurs, count becomes all 0 and overflow sets. overflow stays set until clear or reset. Counting continues after wrap.
- display = lap register in LAP, otherwise count (combinational select).
- running and lap_active are decoded directly from the state register.
- Reset asserted mid-operation overrides everything immediately. After release, the block waits in IDLE.

Test Plan:
- Reset then start (PRESCALE=2, DIGITS=2): start_stop pulse at cycle 0 -> count=00 until edge 2, then 01; tick high every 2nd cycle; running=1.
- Carry chain (DIGITS=2, PRESCALE=1): run from 00 for 9 ticks -> 09; next tick -> 10; 99 reached after 99 ticks; next tick -> 00 with overflow=1; overflow still 1 after 5 more ticks.
- Lap freeze (PRESCALE=1): lap pulse when count=07 -> display holds 07 while count advances to 12; second lap pulse -> display follows count next cycle.
- Pause/resume (PRESCALE=4): pause when prescaler=2 -> count frozen for 10 cycles; after resume, next increment occurs 2 cycles later.
- Simultaneous pulses: clear+start_stop in RUN -> IDLE with count 00; start_stop+lap in RUN -> PAUSE with lap_active=0.
- Async reset mid-LAP: drive reset low between clock edges -> all outputs 0 immediately; after release, a start_stop pulse restarts from 00.

Source files
------------

// File: rtl/bcd_stopwatch_ctrl_if.sv
// Stopwatch front-panel / display bus.
// Groups the panel pulses (start_stop, lap, clear) and the display-side
// outputs (display, count, running, lap_active, overflow, tick).
//   master : panel/display side (drives pulses, observes outputs)
//   slave  : stopwatch controller
interface bcd_stopwatch_ctrl_if #(
   parameter int DIGITS = 4
);
   logic                  start_stop;
   logic                  lap;
   logic                  clear;
   logic [4*DIGITS-1:0]   display;
   logic [4*DIGITS-1:0]   count;
   logic                  running;
   logic                  lap_active;
   logic                  overflow;
   logic                  tick;

   modport master (
      output start_stop, lap, clear,
      input  display, count, running, lap_active, overflow, tick
   );

   modport slave (
      input  start_stop, lap, clear,
      output display, count, running, lap_active, overflow, tick
   );
endinterface

// File: rtl/bcd_stopwatch_ctrl.sv
// BCD stopwatch controller: run/pause/lap state machine, tick prescaler,
// carry-chained decade counter and lap-freezable display select.
// Ports:
//   clock  - system clock, rising edge
//   reset  - asynchronous active-low reset
//   bus    - bcd_stopwatch_ctrl_if.slave (panel pulses in, display/status out)
//
// state | meaning
// IDLE  | stopped at zero, waiting for start_stop
// RUN   | counting, display follows count
// PAUSE | counting suspended, prescaler holds its partial period
// LAP   | counting, display frozen on captured lap value
module bcd_stopwatch_ctrl #(
   parameter int DIGITS   = 4,
   parameter int PRESCALE = 10
) (
   input logic             clock,
   input logic             reset,
   bcd_stopwatch_ctrl_if.slave bus
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] RUN   = 2'd1;
   localparam logic [1:0] PAUSE = 2'd2;
   localparam logic [1:0] LAP   = 2'd3;

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PSC_LAST = PW'(PRESCALE - 1);

   logic [1:0]            state;
   logic [PW-1:0]         psc;
   logic [4*DIGITS-1:0]   count_q;
   logic [4*DIGITS-1:0]   lap_q;
   logic [4*DIGITS-1:0]   count_inc;
   logic                  ovf_q;
   logic                  all9;
   logic                  carry;
   logic                  active;
   logic                  tick;

   assign active = (state == RUN) || (state == LAP);
   assign tick   = active && (psc == PSC_LAST);

   // Ripple carry: a digit steps only when every digit below it is 9.
   // ">= 9" wraps to 0 so an out-of-range digit can never persist.
   always_comb begin
      carry     = 1'b1;
      count_inc = count_q;
      for (int d = 0; d < DIGITS; d++) begin
         if (carry) begin
            count_inc[4*d +: 4] = (count_q[4*d +: 4] >= 4'd9) ? 4'd0
                                  : count_q[4*d +: 4] + 4'd1;
         end
         carry = carry & (count_q[4*d +: 4] == 4'd9);
      end
      all9 = carry;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         psc     <= '0;
         count_q <= '0;
         lap_q   <= '0;
         ovf_q   <= 1'b0;
      end else if (bus.clear) begin
         // clear wins over everything, including a coincident tick
         state   <= IDLE;
         psc     <= '0;
         count_q <= '0;
         lap_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         if (tick) begin
            count_q <= count_inc;
            if (all9) ovf_q <= 1'b1;
         end
         if (active) psc <= tick ? '0 : psc + PW'(1);

         case (state)
            IDLE: if (bus.start_stop) state <= RUN;
            RUN: begin
               if (bus.start_stop) begin
                  state <= PAUSE;
               end else if (bus.lap) begin
                  state <= LAP;
                  lap_q <= tick ? count_inc : count_q;
               end
            end
            LAP: begin
               if (bus.start_stop)  state <= PAUSE;
               else if (bus.lap)    state <= RUN;
            end
            PAUSE: if (bus.start_stop) state <= RUN;
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.count      = count_q;
   assign bus.display    = (state == LAP) ? lap_q : count_q;
   assign bus.running    = active;
   assign bus.lap_active = (state == LAP);
   assign bus.overflow   = ovf_q;
   assign bus.tick       = tick;

endmodule
